lcd_bus_receiver: RTL and testbench

//  Panel-side receiver for the KS0108-style bus driven by lcd_ctrl (LCD_rst, LCD_cs, LCD_rw, LCD_di, LCD_data, LCD_en).
//  It decodes every bus transaction into per-chip controller state and stores data writes in a 2x8x64-byte frame buffer.
//  A registered read port exposes the frame buffer, so benches and on-chip self-check logic can verify what the display shows.
//  It uses the same system clock as the design. The bus is treated as asynchronous and is synchronised internally.

---
 rtl/lcd_bus_receiver.sv | 161 ++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// Panel-side KS0108 bus receiver: per-chip controller state plus a 2x8x64 frame buffer with a registered read port.
// Latency: bus effects and pulses appear 3 clk edges after LCD_en=0 is first sampled; rd_data 1 cycle. No backpressure.
module lcd_bus_receiver #(
  parameter bit CS_ACTIVE_HIGH = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_lcd_rst,
  input  logic [1:0] i_lcd_cs,
  input  logic       i_lcd_rw,
  input  logic       i_lcd_di,
  input  logic [7:0] i_lcd_data,
  input  logic       i_lcd_en,
  input  logic       i_rd_chip,
  input  logic [2:0] i_rd_page,
  input  logic [5:0] i_rd_y,
  output logic [7:0] o_rd_data,
  output logic [1:0] o_disp_on,
  output logic [5:0] o_start_line0,
  output logic [5:0] o_start_line1,
  output logic       o_wr_strobe,
  output logic       o_err
);

  typedef struct packed {
    logic       lcd_rst;
    logic [1:0] cs;
    logic       rw;
    logic       di;
    logic [7:0] dat;
    logic       en;
  } bus_t;

  bus_t       w_bus_in;
  bus_t       r_bus_s1;
  bus_t       r_bus_s2;
  logic       r_en_s3;
  logic       w_fall;
  logic [1:0] w_sel;

  bus_t       r_txn;
  logic [1:0] r_txn_sel;
  logic       r_txn_vld;

  logic [2:0] r_page [2];
  logic [5:0] r_y    [2];
  logic [5:0] r_start[2];
  logic [1:0] r_on;
  logic [2:0] w_page_nxt [2];
  logic [5:0] w_y_nxt    [2];
  logic [5:0] w_start_nxt[2];
  logic [1:0] w_on_nxt;
  logic [1:0] w_we;
  logic       w_wr_pulse;
  logic       w_err_pulse;

  logic [7:0] r_fb [1024];

  assign w_bus_in = '{lcd_rst: i_lcd_rst, cs: i_lcd_cs, rw: i_lcd_rw, di: i_lcd_di,
                      dat: i_lcd_data, en: i_lcd_en};
  assign w_fall   = r_en_s3 & ~r_bus_s2.en;
  assign w_sel    = CS_ACTIVE_HIGH ? r_bus_s2.cs : ~r_bus_s2.cs;

  // Reset clears en history to 0, so a fall only counts after en was seen high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_s1  <= '0;
      r_bus_s2  <= '0;
      r_en_s3   <= 1'b0;
      r_txn     <= '0;
      r_txn_sel <= 2'b00;
      r_txn_vld <= 1'b0;
    end else begin
      r_bus_s1  <= w_bus_in;
      r_bus_s2  <= r_bus_s1;
      r_en_s3   <= r_bus_s2.en;
      r_txn_vld <= w_fall & (|w_sel);
      if (w_fall) begin
        r_txn     <= r_bus_s2;
        r_txn_sel <= w_sel;
      end
    end
  end

  always_comb begin
    w_page_nxt  = r_page;
    w_y_nxt     = r_y;
    w_start_nxt = r_start;
    w_on_nxt    = r_on;
    w_we        = 2'b00;
    w_wr_pulse  = 1'b0;
    w_err_pulse = 1'b0;
    if (!r_bus_s2.lcd_rst) begin
      for (int c = 0; c < 2; c++) begin
        w_page_nxt[c]  = '0;
        w_y_nxt[c]     = '0;
        w_start_nxt[c] = '0;
      end
      w_on_nxt = 2'b00;
    end else if (r_txn_vld) begin
      if (r_txn.rw) begin
        w_err_pulse = 1'b1;
      end else if (r_txn.di) begin
        w_wr_pulse = 1'b1;
        w_we       = r_txn_sel;
        for (int c = 0; c < 2; c++)
          if (r_txn_sel[c]) w_y_nxt[c] = 6'(r_y[c] + 6'd1);
      end else if (r_txn.dat[7:1] == 7'b0011111) begin
        for (int c = 0; c < 2; c++)
          if (r_txn_sel[c]) w_on_nxt[c] = r_txn.dat[0];
      end else if (r_txn.dat[7:6] == 2'b01) begin
        for (int c = 0; c < 2; c++)
          if (r_txn_sel[c]) w_y_nxt[c] = r_txn.dat[5:0];
      end else if (r_txn.dat[7:3] == 5'b10111) begin
        for (int c = 0; c < 2; c++)
          if (r_txn_sel[c]) w_page_nxt[c] = r_txn.dat[2:0];
      end else if (r_txn.dat[7:6] == 2'b11) begin
        for (int c = 0; c < 2; c++)
          if (r_txn_sel[c]) w_start_nxt[c] = r_txn.dat[5:0];
      end else begin
        w_err_pulse = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < 2; c++) begin
        r_page[c]  <= '0;
        r_y[c]     <= '0;
        r_start[c] <= '0;
      end
      r_on        <= 2'b00;
      o_wr_strobe <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      r_page      <= w_page_nxt;
      r_y         <= w_y_nxt;
      r_start     <= w_start_nxt;
      r_on        <= w_on_nxt;
      o_wr_strobe <= w_wr_pulse;
      o_err       <= w_err_pulse;
    end
  end

  // Both chips may write in the same cycle; their addresses differ in the chip bit.
  always_ff @(posedge i_clk) begin
    if (w_we[0]) r_fb[{1'b0, r_page[0], r_y[0]}] <= r_txn.dat;
    if (w_we[1]) r_fb[{1'b1, r_page[1], r_y[1]}] <= r_txn.dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rd_data <= 8'h00;
    else          o_rd_data <= r_fb[{i_rd_chip, i_rd_page, i_rd_y}];
  end

  assign o_disp_on     = r_on;
  assign o_start_line0 = r_start[0];
  assign o_start_line1 = r_start[1];

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed bus transactions, a transaction-level panel model checked every cycle,
// and literal expectations on the key results.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_rst;
  logic [1:0] lcd_cs;
  logic       lcd_rw;
  logic       lcd_di;
  logic [7:0] lcd_data;
  logic       lcd_en;
  logic       rd_chip;
  logic [2:0] rd_page;
  logic [5:0] rd_y;
  logic [7:0] rd_data;
  logic [1:0] disp_on;
  logic [5:0] start_line0;
  logic [5:0] start_line1;
  logic       wr_strobe;
  logic       err;

  lcd_bus_receiver dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lcd_rst(lcd_rst), .i_lcd_cs(lcd_cs),
    .i_lcd_rw(lcd_rw), .i_lcd_di(lcd_di), .i_lcd_data(lcd_data), .i_lcd_en(lcd_en),
    .i_rd_chip(rd_chip), .i_rd_page(rd_page), .i_rd_y(rd_y),
    .o_rd_data(rd_data), .o_disp_on(disp_on), .o_start_line0(start_line0),
    .o_start_line1(start_line1), .o_wr_strobe(wr_strobe), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 0;

  // Panel model: plain per-chip counters and a byte array
  logic [7:0] m_fb  [1024];
  bit         m_vld [1024];
  int         m_pg[2], m_y[2], m_st[2];
  bit         m_on[2];
  bit         m_rst_low = 0;

  bit         tx_pend = 0;
  int         tx_cyc;
  logic [1:0] tx_cs;
  logic       tx_rw, tx_di;
  logic [7:0] tx_dat;
  bit         rst_pend = 0;
  int         rst_cyc;
  logic       rst_val;
  int         prev_addr;
  bit         prev_ok = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  function automatic void model_apply(input logic [1:0] cs, input logic rw, input logic di,
                                      input logic [7:0] d, output bit ew, output bit ee);
    ew = 0;
    ee = 0;
    if (cs == 2'b00) return;
    if (rw) begin
      ee = 1;
      return;
    end
    if (di) begin
      ew = 1;
      for (int c = 0; c < 2; c++)
        if (cs[c]) begin
          m_fb [c * 512 + m_pg[c] * 64 + m_y[c]] = d;
          m_vld[c * 512 + m_pg[c] * 64 + m_y[c]] = 1;
          m_y[c] = (m_y[c] + 1) % 64;
        end
      return;
    end
    for (int c = 0; c < 2; c++) begin
      if (!cs[c]) continue;
      if (d == 8'h3E)                    m_on[c] = 0;
      else if (d == 8'h3F)               m_on[c] = 1;
      else if (d >= 8'h40 && d < 8'h80)  m_y[c]  = int'(d) - 64;
      else if (d >= 8'hB8 && d <= 8'hBF) m_pg[c] = int'(d) - 184;
      else if (d >= 8'hC0)               m_st[c] = int'(d) - 192;
    end
    ee = !(d == 8'h3E || d == 8'h3F || (d >= 8'h40 && d < 8'h80) ||
           (d >= 8'hB8 && d <= 8'hBF) || d >= 8'hC0);
  endfunction

  always @(negedge clk) begin
    bit ew, ee;
    if (chk_en) begin
      if (prev_ok && m_vld[prev_addr]) check("rd_data", rd_data, m_fb[prev_addr]);
      ew = 0;
      ee = 0;
      if (rst_pend && cyc == rst_cyc) begin
        m_rst_low = (rst_val == 1'b0);
        rst_pend  = 0;
      end
      if (m_rst_low)
        for (int c = 0; c < 2; c++) begin
          m_pg[c] = 0; m_y[c] = 0; m_st[c] = 0; m_on[c] = 0;
        end
      if (tx_pend && cyc == tx_cyc) begin
        tx_pend = 0;
        if (!m_rst_low) model_apply(tx_cs, tx_rw, tx_di, tx_dat, ew, ee);
      end
      check("disp_on", {30'd0, disp_on}, {30'd0, m_on[1], m_on[0]});
      check("start_line0", {26'd0, start_line0}, m_st[0]);
      check("start_line1", {26'd0, start_line1}, m_st[1]);
      check("wr_strobe", {31'd0, wr_strobe}, {31'd0, ew});
      check("err", {31'd0, err}, {31'd0, ee});
      prev_addr = int'({rd_chip, rd_page, rd_y});
      prev_ok   = 1;
    end
  end

  // Raise en, hold, drop it; the model applies the transaction 4 counted edges later.
  task automatic bus_drop(input logic [1:0] cs, input logic rw, input logic di, input logic [7:0] d);
    lcd_cs = cs; lcd_rw = rw; lcd_di = di; lcd_data = d; lcd_en = 1'b1;
    repeat (3) tick();
    lcd_en  = 1'b0;
    tx_cs   = cs; tx_rw = rw; tx_di = di; tx_dat = d;
    tx_cyc  = cyc + 4;
    tx_pend = 1;
  endtask

  task automatic xfer(input logic [1:0] cs, input logic rw, input logic di, input logic [7:0] d);
    bus_drop(cs, rw, di, d);
    repeat (6) tick();
  endtask

  task automatic set_lcd_rst(input logic v);
    lcd_rst  = v;
    rst_val  = v;
    rst_cyc  = cyc + 3;
    rst_pend = 1;
  endtask

  task automatic set_rd(input logic ch, input logic [2:0] pg, input logic [5:0] y);
    rd_chip = ch; rd_page = pg; rd_y = y;
  endtask

  initial begin
    int w0, e0;
    for (int i = 0; i < 1024; i++) begin
      m_fb[i] = 8'h00; m_vld[i] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      m_pg[c] = 0; m_y[c] = 0; m_st[c] = 0; m_on[c] = 0;
    end
    rst_n = 1'b0; lcd_rst = 1'b1; lcd_cs = 2'b00; lcd_rw = 1'b0; lcd_di = 1'b0;
    lcd_data = 8'h00; lcd_en = 1'b0;
    set_rd(1'b0, 3'd3, 6'd62);
    repeat (3) tick();
    check("rst_disp_on", {30'd0, disp_on}, 32'd0);
    check("rst_start0", {26'd0, start_line0}, 32'd0);
    check("rst_start1", {26'd0, start_line1}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_en = 1;

    xfer(2'b01, 1'b0, 1'b0, 8'hB8 | 8'd3);
    xfer(2'b01, 1'b0, 1'b0, 8'h40 | 8'd62);
    xfer(2'b01, 1'b0, 1'b1, 8'hAA);
    xfer(2'b01, 1'b0, 1'b1, 8'hBB);
    xfer(2'b01, 1'b0, 1'b1, 8'hCC);
    check("wr_pulses_3", wr_cnt, 3);
    set_rd(1'b0, 3'd3, 6'd62); repeat (2) tick(); check("fb_0_3_62", {24'd0, rd_data}, 32'hAA);
    set_rd(1'b0, 3'd3, 6'd63); repeat (2) tick(); check("fb_0_3_63", {24'd0, rd_data}, 32'hBB);
    set_rd(1'b0, 3'd3, 6'd0);  repeat (2) tick(); check("fb_0_3_0_wrap", {24'd0, rd_data}, 32'hCC);

    xfer(2'b11, 1'b0, 1'b0, 8'h3F);
    xfer(2'b11, 1'b0, 1'b0, 8'hC5);
    check("both_on", {30'd0, disp_on}, 32'd3);
    check("start0_5", {26'd0, start_line0}, 32'd5);
    check("start1_5", {26'd0, start_line1}, 32'd5);
    xfer(2'b10, 1'b0, 1'b0, 8'h3E);
    check("chip1_off", {30'd0, disp_on}, 32'd1);

    xfer(2'b01, 1'b0, 1'b0, 8'h12);
    check("err_bad_instr", err_cnt, 1);
    check("bad_instr_no_change", {30'd0, disp_on}, 32'd1);
    xfer(2'b01, 1'b1, 1'b1, 8'h00);
    check("err_read", err_cnt, 2);
    xfer(2'b01, 1'b0, 1'b1, 8'hDD);
    set_rd(1'b0, 3'd3, 6'd1); repeat (2) tick(); check("y_not_bumped_by_read", {24'd0, rd_data}, 32'hDD);

    w0 = wr_cnt;
    set_lcd_rst(1'b0);
    repeat (6) tick();
    check("lcdrst_disp_on", {30'd0, disp_on}, 32'd0);
    check("lcdrst_start0", {26'd0, start_line0}, 32'd0);
    check("lcdrst_start1", {26'd0, start_line1}, 32'd0);
    xfer(2'b01, 1'b0, 1'b1, 8'h77);
    xfer(2'b11, 1'b0, 1'b0, 8'h3F);
    check("lcdrst_no_strobe", wr_cnt, w0);
    check("lcdrst_still_off", {30'd0, disp_on}, 32'd0);
    set_rd(1'b0, 3'd3, 6'd62); repeat (2) tick(); check("fb_retained", {24'd0, rd_data}, 32'hAA);
    set_lcd_rst(1'b1);
    repeat (5) tick();

    w0 = wr_cnt; e0 = err_cnt;
    xfer(2'b00, 1'b0, 1'b1, 8'h55);
    check("nocs_no_strobe", wr_cnt, w0);
    check("nocs_no_err", err_cnt, e0);

    xfer(2'b01, 1'b0, 1'b0, 8'hB8 | 8'd1);
    xfer(2'b01, 1'b0, 1'b0, 8'h40 | 8'd10);
    xfer(2'b01, 1'b0, 1'b1, 8'h5A);
    xfer(2'b01, 1'b0, 1'b0, 8'h40 | 8'd10);
    set_rd(1'b0, 3'd1, 6'd10);
    bus_drop(2'b01, 1'b0, 1'b1, 8'hA5);
    repeat (4) tick();
    check("rd_old_in_write_cycle", {24'd0, rd_data}, 32'h5A);
    check("strobe_in_write_cycle", {31'd0, wr_strobe}, 32'd1);
    tick();
    check("rd_new_next_cycle", {24'd0, rd_data}, 32'hA5);
    repeat (3) tick();

    xfer(2'b10, 1'b0, 1'b0, 8'hB8 | 8'd6);
    xfer(2'b10, 1'b0, 1'b0, 8'h40 | 8'd20);
    w0 = wr_cnt;
    xfer(2'b11, 1'b0, 1'b1, 8'h3C);
    check("dual_one_strobe", wr_cnt, w0 + 1);
    set_rd(1'b1, 3'd6, 6'd20); repeat (2) tick(); check("dual_chip1", {24'd0, rd_data}, 32'h3C);
    set_rd(1'b0, 3'd1, 6'd11); repeat (2) tick(); check("dual_chip0", {24'd0, rd_data}, 32'h3C);

    repeat (3) tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
